ysyx_22040759_axi_arb: RTL

Two-port arbiter sharing the core's single AXI bridge master between the instruction-fetch port (read-only) and the memory-access port (read/write). Sits between the IF/MEM stages and the AXI bridge. Serialises one transaction at a time, holds the grant until the downstream handshake completes, and routes the response back to the owning requester.

---
 rtl/ysyx_22040759_axi_arb.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/ysyx_22040759_axi_arb.sv
// Two-port AXI bridge arbiter: IF fetch (read-only) and MEM load/store share one bridge master.
// Latency: grant registered (request visible 1 cycle after valid sampled); ready/data combinational from rw_ready.
// Backpressure: one transaction at a time, grant held until rw_ready; loser sees ready=0; 1 IDLE bubble after each completion.
// Option: define YSYX_22040759_ARB_RR_EN for round-robin on simultaneous requests (default: MEM over IF).
module ysyx_22040759_axi_arb #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_valid,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic [1:0]          if_size,
  output logic                if_ready,
  output logic [DATA_W-1:0]   if_data_read,
  output logic [1:0]          if_resp,
  input  logic                mem_valid,
  input  logic                mem_req,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [1:0]          mem_size,
  input  logic [DATA_W-1:0]   mem_w_data,
  input  logic [DATA_W/8-1:0] mem_w_mask,
  output logic                mem_ready,
  output logic [DATA_W-1:0]   mem_data_read,
  output logic [1:0]          mem_resp,
  output logic                rw_valid,
  output logic                rw_req,
  output logic [ADDR_W-1:0]   rw_addr,
  output logic [1:0]          rw_size,
  output logic [DATA_W-1:0]   rw_w_data,
  output logic [DATA_W/8-1:0] rw_w_mask,
  input  logic                rw_ready,
  input  logic [DATA_W-1:0]   rw_r_data,
  input  logic [1:0]          rw_resp,
  output logic                arb_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_IF  = 2'd1,
    GNT_MEM = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_arb_err;
  logic   w_done;

  // A completion only counts outside reset, so an aborted transaction never pulses ready.
  assign w_done  = rw_ready & rst;
  assign arb_err = r_arb_err;

  // State register; reset aborts any in-flight grant.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

`ifdef YSYX_22040759_ARB_RR_EN
  logic r_last_mem;  // 1: MEM was granted most recently, 0: IF

  // Remember the owner of every new grant for round-robin tie-breaking.
  always_ff @(posedge clk) begin
    if (!rst)                                        r_last_mem <= 1'b0;
    else if (r_state == IDLE && w_next == GNT_MEM)   r_last_mem <= 1'b1;
    else if (r_state == IDLE && w_next == GNT_IF)    r_last_mem <= 1'b0;
  end
`endif

  // Next-state: pick a requester in IDLE, hold the grant until the bridge completes.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (if_valid && mem_valid) begin
`ifdef YSYX_22040759_ARB_RR_EN
          w_next = r_last_mem ? GNT_IF : GNT_MEM;
`else
          w_next = GNT_MEM;
`endif
        end else if (mem_valid) begin
          w_next = GNT_MEM;
        end else if (if_valid) begin
          w_next = GNT_IF;
        end
      end
      GNT_IF, GNT_MEM: begin
        if (rw_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Outputs: route granted port to the bridge and the bridge response back to its owner.
  always_comb begin
    rw_valid      = 1'b0;
    rw_req        = 1'b0;
    rw_addr       = '0;
    rw_size       = '0;
    rw_w_data     = '0;
    rw_w_mask     = '0;
    if_ready      = 1'b0;
    if_data_read  = '0;
    if_resp       = '0;
    mem_ready     = 1'b0;
    mem_data_read = '0;
    mem_resp      = '0;
    case (r_state)
      GNT_IF: begin
        rw_valid = 1'b1;
        rw_addr  = if_addr;
        rw_size  = if_size;
        if (w_done) begin
          if_ready     = 1'b1;
          if_data_read = rw_r_data;
          if_resp      = rw_resp;
        end
      end
      GNT_MEM: begin
        rw_valid  = 1'b1;
        rw_req    = mem_req;
        rw_addr   = mem_addr;
        rw_size   = mem_size;
        rw_w_data = mem_w_data;
        rw_w_mask = mem_w_mask;
        if (w_done) begin
          mem_ready     = 1'b1;
          mem_data_read = rw_r_data;
          mem_resp      = rw_resp;
        end
      end
      default: ;
    endcase
  end

  // Sticky error flag for any non-OKAY completion seen while granted.
  always_ff @(posedge clk) begin
    if (!rst)                                             r_arb_err <= 1'b0;
    else if (r_state != IDLE && rw_ready && rw_resp != 2'b00) r_arb_err <= 1'b1;
  end

endmodule
